// File: rtl/wb_dbg_bridge_if.sv
// Wishbone B3 classic signal bundle between one bus master and its arbiter slot.
// Latency: none, wires only.
// Backpressure: the slave stalls the master by withholding ack/err/rty.
interface wishbone_b3 #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   dat_m2s;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            ack;
    logic            err;
    logic            rty;
    logic [DW-1:0]   dat_s2m;

    modport master (
        output adr, cyc, stb, we, sel, dat_m2s, cti, bte,
        input  ack, err, rty, dat_s2m
    );

    modport slave (
        input  adr, cyc, stb, we, sel, dat_m2s, cti, bte,
        output ack, err, rty, dat_s2m
    );
endinterface

// File: rtl/wb_dbg_bridge.sv
// Debug-host single-word access to Wishbone classic master, with rty re-issue and error status.
// Latency: request sampled, bus cycle next clock; dbg_ack no earlier than 2 clocks after dbg_stb.
// Backpressure: 4-phase handshake, dbg_ack held until dbg_stb drops; optional bus timeout via WB_DBG_TIMEOUT_EN.
module wb_dbg_bridge #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int MAX_RETRY  = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dbg_stb,
    input  logic                  dbg_we,
    input  logic [addr_width-1:0] dbg_adr,
    input  logic [data_width-1:0] dbg_dat_i,
    output logic [data_width-1:0] dbg_dat_o,
    output logic                  dbg_ack,
    output logic                  dbg_err,
    wishbone_b3.master            wb
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUS     = 2'd1;
    localparam logic [1:0] S_BACKOFF = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;
    localparam int         SELW      = data_width / 8;

    if (MAX_RETRY < 0 || MAX_RETRY > 15 || TIMEOUT < 1) begin : g_param_chk
        $error("wb_dbg_bridge: MAX_RETRY must be 0..15 and TIMEOUT at least 1");
    end

    logic [1:0]            state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [addr_width-1:0] adr_q, adr_d;
    logic [data_width-1:0] wdat_q, wdat_d;
    logic [SELW-1:0]       sel_q, sel_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [data_width-1:0] rdat_q, rdat_d;
    logic [3:0]            retry_q, retry_d;
    logic                  fail;

`ifdef WB_DBG_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit;

    // Counts silent BUS cycles; abort on the cycle that brings the count to TIMEOUT.
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (state_q != S_BUS) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        ack_d   = ack_q;
        err_d   = err_q;
        rdat_d  = rdat_q;
        retry_d = retry_q;
        fail    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dbg_stb) begin
                    adr_d   = dbg_adr;
                    we_d    = dbg_we;
                    wdat_d  = dbg_dat_i;
                    sel_d   = '1;
                    cyc_d   = 1'b1;
                    retry_d = 4'd0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (wb.ack) begin
                    cyc_d   = 1'b0;
                    if (!we_q) begin
                        rdat_d = wb.dat_s2m;
                    end
                    err_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_DONE;
                end else if (wb.err || (wb.rty && retry_q >= 4'(MAX_RETRY))) begin
                    fail = 1'b1;
                end else if (wb.rty) begin
                    cyc_d   = 1'b0;
                    retry_d = retry_q + 4'd1;
                    state_d = S_BACKOFF;
`ifdef WB_DBG_TIMEOUT_EN
                end else if (tmo_hit) begin
                    fail = 1'b1;
`endif
                end
            end
            S_BACKOFF: begin
                cyc_d   = 1'b1;
                state_d = S_BUS;
            end
            default: begin
                if (!dbg_stb) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
        if (fail) begin
            cyc_d   = 1'b0;
            rdat_d  = '0;
            err_d   = 1'b1;
            ack_d   = 1'b1;
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            retry_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            retry_q <= retry_d;
        end
    end

    assign wb.adr     = adr_q;
    assign wb.cyc     = cyc_q;
    assign wb.stb     = cyc_q;
    assign wb.we      = we_q;
    assign wb.sel     = sel_q;
    assign wb.dat_m2s = wdat_q;
    assign wb.cti     = 3'b000;
    assign wb.bte     = 2'b00;
    assign dbg_ack    = ack_q;
    assign dbg_err    = err_q;
    assign dbg_dat_o  = rdat_q;
endmodule

// File: tb/tb_wb_dbg_bridge.sv
// Directed bench for wb_dbg_bridge: scripted Wishbone slave plus cyc-pulse monitor.
module tb_wb_dbg_bridge;
`ifdef WB_DBG_TIMEOUT_EN
    localparam int TMO = 10;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dbg_stb;
    logic        dbg_we;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_dat_i;
    logic [31:0] dbg_dat_o;
    logic        dbg_ack;
    logic        dbg_err;

    wishbone_b3 #(.AW(32), .DW(32)) wb_bus ();

    wb_dbg_bridge #(
        .addr_width(32), .data_width(32), .MAX_RETRY(3), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dbg_stb(dbg_stb), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_dat_i(dbg_dat_i),
        .dbg_dat_o(dbg_dat_o), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
        .wb(wb_bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Slave script: response after slv_delay cyc-cycles; 0 ack, 1 err, 2 silent, 3 rty.
    int          slv_delay = 1;
    int          slv_mode  = 0;
    int          rty_until = 0;
    logic [31:0] slv_data  = '0;
    logic        stray     = 1'b0;

    // Monitor statistics, cumulative; the bench reads deltas.
    int          pulses = 0, gap1 = 0, unstable = 0;
    int          cur_len = 0, last_len = 0, idle_len = 100;
    logic        prev_cyc = 1'b0;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;

    initial begin
        wb_bus.ack = 1'b0; wb_bus.err = 1'b0; wb_bus.rty = 1'b0; wb_bus.dat_s2m = '0;
    end

    always @(negedge clk) begin
        if (wb_bus.cyc && !prev_cyc) begin
            pulses++;
            if (idle_len == 1) gap1++;
            cur_len = 1;
            cap_adr = wb_bus.adr; cap_dat = wb_bus.dat_m2s;
            cap_we  = wb_bus.we;  cap_sel = wb_bus.sel;
        end else if (wb_bus.cyc) begin
            cur_len++;
            if (wb_bus.adr !== cap_adr || wb_bus.dat_m2s !== cap_dat ||
                wb_bus.we !== cap_we || wb_bus.sel !== cap_sel) unstable++;
        end else begin
            if (prev_cyc) begin
                last_len = cur_len;
                idle_len = 1;
            end else begin
                idle_len++;
            end
        end
        prev_cyc = wb_bus.cyc;
        wb_bus.ack = 1'b0; wb_bus.err = 1'b0; wb_bus.rty = 1'b0;
        wb_bus.dat_s2m = slv_data;
        if (wb_bus.cyc && cur_len >= slv_delay) begin
            if (pulses <= rty_until) wb_bus.rty = 1'b1;
            else if (slv_mode == 0) wb_bus.ack = 1'b1;
            else if (slv_mode == 1) wb_bus.err = 1'b1;
            else if (slv_mode == 3) wb_bus.rty = 1'b1;
        end
        if (stray && !wb_bus.cyc) wb_bus.ack = 1'b1;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
        dbg_we = w; dbg_adr = a; dbg_dat_i = d; dbg_stb = 1'b1;
    endtask

    task automatic wait_ack(input string tag, input int budget, output int lat);
        lat = 0;
        while (!dbg_ack && lat < budget) begin
            tick();
            lat++;
        end
        chk({tag, "_ack_seen"}, {31'd0, dbg_ack}, 32'd1);
    endtask

    task automatic release_req(input string tag);
        dbg_stb = 1'b0;
        tick();
        chk({tag, "_ack_drop"}, {31'd0, dbg_ack}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat, p0, g0, u0, n;
        rst_n = 1'b0; dbg_stb = 1'b0; dbg_we = 1'b0; dbg_adr = '0; dbg_dat_i = '0;
        repeat (3) tick();
        chk("rst_cyc_stb_we", {29'd0, wb_bus.cyc, wb_bus.stb, wb_bus.we}, 32'd0);
        chk("rst_adr", wb_bus.adr, 32'd0);
        chk("rst_dat_m2s", wb_bus.dat_m2s, 32'd0);
        chk("rst_sel_cti_bte", {23'd0, wb_bus.sel, wb_bus.cti, wb_bus.bte}, 32'd0);
        chk("rst_dbg", {30'd0, dbg_ack, dbg_err}, 32'd0);
        chk("rst_dat_o", dbg_dat_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // Ack with no cycle open must not start anything.
        stray = 1'b1;
        repeat (3) tick();
        stray = 1'b0;
        chk("stray_ack", {30'd0, dbg_ack, wb_bus.cyc}, 32'd0);

        // Read, 3-cycle slave; request fields scrambled after latching.
        p0 = pulses; u0 = unstable;
        slv_delay = 3; slv_mode = 0; slv_data = 32'hCAFE_0001;
        req(1'b0, 32'h0000_1000, 32'h0);
        tick();
        dbg_adr = 32'hFFFF_FFFC; dbg_we = 1'b1; dbg_dat_i = 32'hDEAD_BEEF;
        wait_ack("rd", 20, lat);
        chk("rd_latency", lat + 1, 32'd4);
        chk("rd_pulses", pulses - p0, 32'd1);
        chk("rd_cyc_len", last_len, 32'd3);
        chk("rd_adr", cap_adr, 32'h0000_1000);
        chk("rd_we_sel", {27'd0, cap_we, cap_sel}, 32'h0000_000F);
        chk("rd_stable", unstable - u0, 32'd0);
        chk("rd_data", dbg_dat_o, 32'hCAFE_0001);
        chk("rd_err", {31'd0, dbg_err}, 32'd0);
        repeat (3) tick();
        chk("rd_ack_hold", {31'd0, dbg_ack}, 32'd1);
        release_req("rd");
        chk("rd_data_kept", dbg_dat_o, 32'hCAFE_0001);

        // Write, same-cycle ack.
        p0 = pulses;
        slv_delay = 1;
        req(1'b1, 32'h0000_2004, 32'h1234_5678);
        wait_ack("wr", 20, lat);
        chk("wr_latency", lat, 32'd2);
        chk("wr_pulses", pulses - p0, 32'd1);
        chk("wr_cyc_len", last_len, 32'd1);
        chk("wr_adr", cap_adr, 32'h0000_2004);
        chk("wr_dat", cap_dat, 32'h1234_5678);
        chk("wr_we", {31'd0, cap_we}, 32'd1);
        chk("wr_dat_o_kept", dbg_dat_o, 32'hCAFE_0001);
        release_req("wr");

        // Bus error on first cycle.
        slv_mode = 1;
        req(1'b0, 32'h0000_3000, 32'h0);
        wait_ack("err", 20, lat);
        chk("err_flag", {31'd0, dbg_err}, 32'd1);
        chk("err_data", dbg_dat_o, 32'd0);
        release_req("err");
        chk("err_flag_kept", {31'd0, dbg_err}, 32'd1);

        // Good read clears the error.
        slv_mode = 0; slv_data = 32'h5555_AAAA;
        req(1'b0, 32'h0000_3004, 32'h0);
        wait_ack("ok", 20, lat);
        chk("ok_err_clr", {31'd0, dbg_err}, 32'd0);
        chk("ok_data", dbg_dat_o, 32'h5555_AAAA);
        release_req("ok");

        // Two retries then ack.
        p0 = pulses; g0 = gap1;
        rty_until = pulses + 2; slv_data = 32'h0000_00AA;
        req(1'b0, 32'h0000_4000, 32'h0);
        wait_ack("rty2", 40, lat);
        chk("rty2_pulses", pulses - p0, 32'd3);
        chk("rty2_gaps", gap1 - g0, 32'd2);
        chk("rty2_err", {31'd0, dbg_err}, 32'd0);
        chk("rty2_data", dbg_dat_o, 32'h0000_00AA);
        release_req("rty2");

        // Retry forever: MAX_RETRY re-issues then failure.
        p0 = pulses; g0 = gap1;
        slv_mode = 3;
        req(1'b0, 32'h0000_4004, 32'h0);
        wait_ack("rtyx", 40, lat);
        chk("rtyx_pulses", pulses - p0, 32'd4);
        chk("rtyx_gaps", gap1 - g0, 32'd3);
        chk("rtyx_err", {31'd0, dbg_err}, 32'd1);
        chk("rtyx_data", dbg_dat_o, 32'd0);
        release_req("rtyx");

        // Silent slave.
        slv_mode = 2; slv_data = 32'h0;
        req(1'b0, 32'h0000_5000, 32'h0);
`ifdef WB_DBG_TIMEOUT_EN
        wait_ack("tmo", 50, lat);
        chk("tmo_cyc_len", last_len, 32'd10);
        chk("tmo_err", {31'd0, dbg_err}, 32'd1);
        release_req("tmo");
        req(1'b0, 32'h0000_5000, 32'h0);
        repeat (3) tick();
`else
        repeat (1000) tick();
        chk("hang_len", {31'd0, (cur_len >= 1000)}, 32'd1);
        chk("hang_no_ack", {31'd0, dbg_ack}, 32'd0);
`endif
        // Async reset while in BUS.
        chk("rst_bus_cyc_pre", {31'd0, wb_bus.cyc}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_bus_cyc", {30'd0, wb_bus.cyc, wb_bus.stb}, 32'd0);
        chk("rst_bus_ack", {31'd0, dbg_ack}, 32'd0);
        dbg_stb = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("rst_after", {30'd0, dbg_ack, wb_bus.cyc}, 32'd0);

        // dbg_stb dropped mid-bus-cycle.
        slv_mode = 0; slv_delay = 4; slv_data = 32'h0000_0077;
        req(1'b0, 32'h0000_6000, 32'h0);
        tick(); tick();
        dbg_stb = 1'b0;
        wait_ack("drop", 20, lat);
        n = 0;
        while (dbg_ack && n < 10) begin
            n++;
            tick();
        end
        chk("drop_ack_len", n, 32'd1);
        chk("drop_data", dbg_dat_o, 32'h0000_0077);
        chk("drop_cyc", {31'd0, wb_bus.cyc}, 32'd0);

        // Back in IDLE: minimum-latency write.
        slv_delay = 1;
        req(1'b1, 32'h0000_6004, 32'hA5A5_5A5A);
        wait_ack("post", 20, lat);
        chk("post_latency", lat, 32'd2);
        release_req("post");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
